xnor_seq_detector: RTL and testbench
====================================

// Module: xnor_seq_detector
// PURPOSE
//  Parametrised, registered successor to the 1-bit XNOR gate. Per sample, computes a masked bitwise
//  XNOR of a WIDTH-bit input against a programmable pattern, then reduces it to a match flag.
//  Counts consecutive matching samples and pulses detect when the run reaches a programmable threshold.
//  Sits between a sampled data source (switches/shift register) and LED/status logic in board-level tops.
// PARAMETERS
//  WIDTH   8  data/pattern/mask width in bits (>=1)
//  CNT_W   8  width of run counter, threshold and total-hit counter (>=2)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  cfg_we       in   1       load cfg_pattern/cfg_mask/cfg_thresh this edge
//  cfg_pattern  in   WIDTH   reference pattern
//  cfg_mask     in   WIDTH   1 = bit compared, 0 = don't-care
//  cfg_thresh   in   CNT_W   consecutive matches required for detect; 0 disables detect
//  in_valid     in   1       in_data carries a sample this cycle
//  in_data      in   WIDTH   sample
//  out_valid    out  1       out_* reflect the sample accepted on the previous edge
//  out_bits     out  WIDTH   registered ~(in_data ^ pattern) | ~mask
//  out_match    out  1       registered &out_bits
//  run_cnt      out  CNT_W   current consecutive-match run length, saturating
//  hit_cnt      out  CNT_W   total matching samples since reset/config, saturating
//  detect       out  1       one-cycle pulse when run_cnt becomes equal to threshold
// BEHAVIOUR
//  - Clock clk, reset rst: synchronous and active-high; reset acts on the rising edge only.
//  - Reset (edge with rst=1): pattern=0, mask=all-ones, thresh=0; out_valid=0, out_bits=0, out_match=0,
//    run_cnt=0, hit_cnt=0, detect=0. rst overrides cfg_we and in_valid on the same edge.
//  - Latency: 1 cycle. Sample accepted at edge N (in_valid=1, cfg_we=0) -> out_* valid after edge N.
//  - No in_valid: out_valid=0, detect=0; out_bits/out_match, run_cnt, hit_cnt hold.
//  - Accepted match: run_cnt += 1 and hit_cnt += 1, both saturating at 2^CNT_W-1 (never wrap).
//  - Accepted mismatch: run_cnt <= 0; hit_cnt holds.
//  - detect=1 for exactly one cycle when an accepted match moves run_cnt from thresh-1 to thresh, and
//    thresh!=0. Further matches do not re-fire. After a mismatch, detect fires again on the next
//    full run. Saturation does not generate detect.
//  - cfg_we=1 (and rst=0): registers the new pattern/mask/thresh and clears run_cnt and hit_cnt.
//    Any in_valid sample on that edge is dropped: out_valid=0 next cycle, no counting.
//    The new config applies from the next edge.
//  - mask=0: every sample matches. thresh=1: detect on the first match of each run.
//  - Mid-run reset: all state is cleared immediately. No pending detect survives the reset.
// STRUCTURE
//  - Shared package/header xnor_pkg: localparams for default WIDTH/CNT_W and the
//    reset values of pattern and mask. No typedefs are needed.
//  - Sub-module xnor_mask_cmp (combinational): in a, b, mask -> bits = ~(a^b)|~mask, match = &bits.
//    Parametrised by WIDTH; the top instantiates it once.
//  - Top holds the config registers, output register stage, run/hit counters and detect edge logic.
// TESTING
//  - Reset: drive rst for 2 cycles with random inputs -> all outputs 0; cfg readback implied by
//    the next test: pattern=0, mask=FF.
//  - Basic compare: WIDTH=8, cfg pattern=8'hA5, mask=8'hFF. in_data=8'hA5 -> next cycle
//    out_bits=8'hFF, out_match=1. in_data=8'hA4 -> out_bits=8'hFE, out_match=0.
//  - Mask: mask=8'hF0, pattern=8'hA0. in_data=8'hAF -> out_bits=8'hFF, out_match=1.
//    in_data=8'h5F -> out_bits=8'h0F, out_match=0.
//  - Threshold: thresh=3, matches on cycles 1-4 -> run_cnt 1,2,3,4; detect only with run_cnt=3.
//    Then mismatch -> run_cnt=0. Then 3 matches -> detect again. Gap cycles with in_valid=0 hold run_cnt.
//  - Saturation: CNT_W=2, thresh=0, 5 matches -> run_cnt/hit_cnt stop at 3. detect never asserts.
//  - Config/reset collisions: cfg_we with in_valid on the same edge -> out_valid=0 and counters=0.
//    rst with cfg_we -> defaults loaded. rst asserted when run_cnt=2, thresh=3 -> no detect afterwards.

Source files
------------

// File: rtl/xnor_pkg.sv
// Shared constants for the masked-XNOR run detector: default widths and the
// per-bit fill values that configuration registers take on reset.
package xnor_pkg;
  localparam int   DEF_WIDTH        = 8;
  localparam int   DEF_CNT_W        = 8;
  localparam logic PATTERN_RST_FILL = 1'b0;
  localparam logic MASK_RST_FILL    = 1'b1;
endpackage

// File: rtl/xnor_mask_cmp.sv
// Combinational masked XNOR: a bit is "equal" when a and b agree or the bit is
// masked off; match is the AND of all per-bit results.
module xnor_mask_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] bits,
  output logic             match
);
  assign bits  = ~(a ^ b) | ~mask;
  assign match = &bits;
endmodule

// File: rtl/xnor_seq_detector.sv
// Registered masked-XNOR comparator with consecutive-match run counter, total
// hit counter and a one-shot detect pulse when the run reaches the threshold.
module xnor_seq_detector
  import xnor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bits,
  output logic             out_match,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             detect
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] thresh;

  logic [WIDTH-1:0] cmp_bits;
  logic             cmp_match;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] hit_inc;
  logic             detect_nxt;

  xnor_mask_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a     (in_data),
    .b     (pattern),
    .mask  (mask),
    .bits  (cmp_bits),
    .match (cmp_match)
  );

  // Counters saturate; a saturated run never equals thresh-1 on the way up,
  // so saturation alone can never produce a detect.
  always_comb begin
    run_inc    = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_W'(1);
    hit_inc    = (hit_cnt == CNT_MAX) ? hit_cnt : hit_cnt + CNT_W'(1);
    detect_nxt = cmp_match && (thresh != '0) && (run_cnt == thresh - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern   <= {WIDTH{PATTERN_RST_FILL}};
      mask      <= {WIDTH{MASK_RST_FILL}};
      thresh    <= '0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_match <= 1'b0;
      run_cnt   <= '0;
      hit_cnt   <= '0;
      detect    <= 1'b0;
    end else if (cfg_we) begin
      // A sample arriving with a config write is dropped.
      pattern   <= cfg_pattern;
      mask      <= cfg_mask;
      thresh    <= cfg_thresh;
      out_valid <= 1'b0;
      run_cnt   <= '0;
      hit_cnt   <= '0;
      detect    <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_bits  <= cmp_bits;
      out_match <= cmp_match;
      detect    <= detect_nxt;
      if (cmp_match) begin
        run_cnt <= run_inc;
        hit_cnt <= hit_inc;
      end else begin
        run_cnt <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      detect    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xnor_seq_detector.sv
// Scoreboard bench: directed samples push hand-computed responses; monitors
// pop and compare whenever a DUT presents out_valid.
module tb_xnor_seq_detector;
  typedef struct packed {
    logic [7:0] bits;
    logic       match;
    logic [7:0] run;
    logic [7:0] hit;
    logic       det;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0, cfg_mask = '0, cfg_thresh = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid, out_match, detect;
  logic [7:0] out_bits, run_cnt, hit_cnt;

  logic       cfg_we2 = 1'b0;
  logic [7:0] cfg_pattern2 = '0, cfg_mask2 = '0;
  logic [1:0] cfg_thresh2 = '0;
  logic       in_valid2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       out_valid2, out_match2, detect2;
  logic [7:0] out_bits2;
  logic [1:0] run_cnt2, hit_cnt2;

  exp_t q8[$];
  exp_t q2[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  xnor_seq_detector #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_bits(out_bits),
    .out_match(out_match), .run_cnt(run_cnt), .hit_cnt(hit_cnt), .detect(detect)
  );

  xnor_seq_detector #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we2), .cfg_pattern(cfg_pattern2),
    .cfg_mask(cfg_mask2), .cfg_thresh(cfg_thresh2), .in_valid(in_valid2),
    .in_data(in_data2), .out_valid(out_valid2), .out_bits(out_bits2),
    .out_match(out_match2), .run_cnt(run_cnt2), .hit_cnt(hit_cnt2), .detect(detect2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("detect_without_valid", {31'd0, detect & ~out_valid}, 32'd0);
    if (out_valid === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check("out_bits",  {24'd0, out_bits},  {24'd0, e.bits});
        check("out_match", {31'd0, out_match}, {31'd0, e.match});
        check("run_cnt",   {24'd0, run_cnt},   {24'd0, e.run});
        check("hit_cnt",   {24'd0, hit_cnt},   {24'd0, e.hit});
        check("detect",    {31'd0, detect},    {31'd0, e.det});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid2 === 1'b1) begin
      if (q2.size() == 0) begin
        check("unexpected_out_valid2", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("sat_run_cnt", {30'd0, run_cnt2}, {24'd0, e.run});
        check("sat_hit_cnt", {30'd0, hit_cnt2}, {24'd0, e.hit});
        check("sat_detect",  {31'd0, detect2},  {31'd0, e.det});
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] eb, input logic em,
                      input logic [7:0] er, input logic [7:0] eh, input logic ed);
    in_valid = 1'b1;
    in_data  = d;
    q8.push_back('{bits: eb, match: em, run: er, hit: eh, det: ed});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic [7:0] er, input logic [7:0] eh);
    in_valid2 = 1'b1;
    in_data2  = d;
    q2.push_back('{bits: 8'hFF, match: 1'b1, run: er, hit: eh, det: 1'b0});
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [7:0] m, input logic [7:0] t);
    cfg_we = 1'b1; cfg_pattern = p; cfg_mask = m; cfg_thresh = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_bits"},  {24'd0, out_bits},  32'd0);
    check({tag, "_out_match"}, {31'd0, out_match}, 32'd0);
    check({tag, "_run_cnt"},   {24'd0, run_cnt},   32'd0);
    check({tag, "_hit_cnt"},   {24'd0, hit_cnt},   32'd0);
    check({tag, "_detect"},    {31'd0, detect},    32'd0);
  endtask

  initial begin
    // Reset with random inputs toggling underneath.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cfg_we = 1'($urandom_range(0, 1)); cfg_pattern = 8'($urandom);
      cfg_mask = 8'($urandom); cfg_thresh = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
      in_valid2 = 1'($urandom_range(0, 1)); in_data2 = 8'($urandom);
      @(posedge clk); #1;
    end
    check_cleared("reset");
    check("reset_run_cnt2", {30'd0, run_cnt2}, 32'd0);
    check("reset_out_valid2", {31'd0, out_valid2}, 32'd0);
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;

    // Default config (pattern 0, mask FF) visible before any cfg write.
    send(8'h00, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);
    send(8'h80, 8'h7F, 1'b0, 8'd0, 8'd1, 1'b0);

    cfg(8'hA5, 8'hFF, 8'd0);
    send(8'hA5, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);
    send(8'hA4, 8'hFE, 1'b0, 8'd0, 8'd1, 1'b0);

    cfg(8'hA0, 8'hF0, 8'd0);
    send(8'hAF, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);
    send(8'h5F, 8'h0F, 1'b0, 8'd0, 8'd1, 1'b0);

    cfg(8'h3C, 8'hFF, 8'd3);
    send(8'h3C, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);
    send(8'h3C, 8'hFF, 1'b1, 8'd2, 8'd2, 1'b0);
    send(8'h3C, 8'hFF, 1'b1, 8'd3, 8'd3, 1'b1);
    send(8'h3C, 8'hFF, 1'b1, 8'd4, 8'd4, 1'b0);
    idle(1);
    check("gap_run_hold", {24'd0, run_cnt}, 32'd4);
    check("gap_out_valid", {31'd0, out_valid}, 32'd0);
    send(8'h00, 8'hC3, 1'b0, 8'd0, 8'd4, 1'b0);
    send(8'h3C, 8'hFF, 1'b1, 8'd1, 8'd5, 1'b0);
    idle(1);
    send(8'h3C, 8'hFF, 1'b1, 8'd2, 8'd6, 1'b0);
    send(8'h3C, 8'hFF, 1'b1, 8'd3, 8'd7, 1'b1);

    cfg(8'h00, 8'h00, 8'd1);
    send(8'h12, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b1);
    send(8'h34, 8'hFF, 1'b1, 8'd2, 8'd2, 1'b0);

    // Config write colliding with a sample: sample dropped, counters cleared.
    in_valid = 1'b1; in_data = 8'h3C;
    cfg(8'h3C, 8'hFF, 8'd3);
    in_valid = 1'b0;
    check("cfg_coll_out_valid", {31'd0, out_valid}, 32'd0);
    check("cfg_coll_run_cnt", {24'd0, run_cnt}, 32'd0);
    check("cfg_coll_hit_cnt", {24'd0, hit_cnt}, 32'd0);

    // Reset wins over cfg_we and in_valid.
    rst = 1'b1; cfg_we = 1'b1; cfg_pattern = 8'h55; cfg_mask = 8'h0F; cfg_thresh = 8'd2;
    in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
    check_cleared("rst_cfg");
    send(8'h00, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);
    send(8'h00, 8'hFF, 1'b1, 8'd2, 8'd2, 1'b0);
    send(8'h01, 8'hFE, 1'b0, 8'd0, 8'd2, 1'b0);

    // Reset mid-run just before the threshold would be reached.
    cfg(8'h3C, 8'hFF, 8'd3);
    send(8'h3C, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);
    send(8'h3C, 8'hFF, 1'b1, 8'd2, 8'd2, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check_cleared("midrun_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_detect", {31'd0, detect}, 32'd0);
    end
    send(8'h00, 8'hFF, 1'b1, 8'd1, 8'd1, 1'b0);

    // Saturation on the CNT_W=2 instance, thresh=0.
    send2(8'h00, 8'd1, 8'd1);
    send2(8'h00, 8'd2, 8'd2);
    send2(8'h00, 8'd3, 8'd3);
    send2(8'h00, 8'd3, 8'd3);
    send2(8'h00, 8'd3, 8'd3);

    idle(2);
    check("q8_drained", q8.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
